cache_stage: RTL and testbench

Data-cache access stage that sits directly downstream of the TLB-lookup stage. It takes the translated address and forwarded control fields, serves loads from a small direct-mapped write-through cache, and forwards stores to memory. On a miss or a store, it stalls the pipeline while a refill/write FSM drives the memory handshake. Its registered outputs feed the write-back stage.

---
 rtl/cache_pkg.sv | 18 +
 rtl/cache_array.sv | 35 +++
 rtl/pipe_reg.sv | 17 +
 rtl/cache_stage.sv | 165 ++++++++++++++++
 tb/tb_cache_stage.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared widths, FSM state and line-entry type for the data-cache stage
package cache_pkg;
    localparam int CACHE_LINES = 4;
    localparam int CACHE_WORDS = 4;
    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 16;
    localparam int OFFSET_W    = $clog2(CACHE_WORDS);
    localparam int INDEX_W     = $clog2(CACHE_LINES);
    localparam int TAG_W       = ADDR_W - OFFSET_W - INDEX_W;

    typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

    typedef struct packed {
        logic                                valid;
        logic [TAG_W-1:0]                    tag;
        logic [CACHE_WORDS-1:0][DATA_W-1:0]  data;
    } line_t;
endpackage

// File: rtl/cache_array.sv
// rtl/cache_array.sv - direct-mapped valid/tag/data storage, one comb read port, word and tag write ports
module cache_array
    import cache_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [INDEX_W-1:0]  rd_index,
    output line_t               rd_line,
    input  logic                word_we,
    input  logic [INDEX_W-1:0]  word_index,
    input  logic [OFFSET_W-1:0] word_offset,
    input  logic [DATA_W-1:0]   word_data,
    input  logic                tag_we,
    input  logic [INDEX_W-1:0]  tag_index,
    input  logic [TAG_W-1:0]    tag_value
);
    line_t lines [CACHE_LINES];

    assign rd_line = lines[rd_index];

    // Only valid bits are reset; tag and data are don't-care until refilled.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CACHE_LINES; i++)
                lines[i].valid <= 1'b0;
        end else begin
            if (word_we)
                lines[word_index].data[word_offset] <= word_data;
            if (tag_we) begin
                lines[tag_index].valid <= 1'b1;
                lines[tag_index].tag   <= tag_value;
            end
        end
    end
endmodule

// File: rtl/pipe_reg.sv
// rtl/pipe_reg.sv - parametric enabled pipeline register with synchronous reset
module pipe_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk) begin
        if (reset)
            q <= '0;
        else if (en)
            q <= d;
    end
endmodule

// File: rtl/cache_stage.sv
// rtl/cache_stage.sv - write-through direct-mapped data-cache stage; CACHE_STATS_EN adds hit/miss counters
module cache_stage
    import cache_pkg::*;
#(
    parameter int LINES          = CACHE_LINES,
    parameter int WORDS_PER_LINE = CACHE_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable_cache,
    input  logic [15:0] tlblookup_result,
    input  logic [2:0]  destReg_addr_input,
    input  logic        we_input,
    input  logic [1:0]  bp_input,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [15:0] store_data,
    output logic [15:0] cache_result,
    output logic [2:0]  destReg_addr_output,
    output logic        we_output,
    output logic [1:0]  bp_output,
    output logic        stall_pipeline,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
`endif
);
    // Geometry lives in cache_pkg; the parameters must agree with it.
    if (LINES != CACHE_LINES || WORDS_PER_LINE != CACHE_WORDS) begin : g_cfg_check
        $error("cache_stage geometry must match cache_pkg");
    end

    state_t              state;
    logic [OFFSET_W-1:0] count;
    logic                store_done;
    line_t               rd_line;

    logic [OFFSET_W-1:0] addr_offset;
    logic [INDEX_W-1:0]  addr_index;
    logic [TAG_W-1:0]    addr_tag;
    logic                hit, last_word, out_en;
    logic                word_we, tag_we;
    logic [21:0]         out_q;

    assign addr_offset = tlblookup_result[OFFSET_W-1:0];
    assign addr_index  = tlblookup_result[OFFSET_W +: INDEX_W];
    assign addr_tag    = tlblookup_result[ADDR_W-1 -: TAG_W];
    assign hit         = rd_line.valid && (rd_line.tag == addr_tag);
    assign last_word   = (count == OFFSET_W'(CACHE_WORDS - 1));

    assign stall_pipeline = (state != IDLE) ||
                            (enable_cache && ((is_load && !hit) || (is_store && !store_done)));
    assign out_en = enable_cache && !stall_pipeline;

    assign word_we = (state == REFILL && mem_ack) ||
                     (state == IDLE && enable_cache && is_store && hit && !store_done);
    assign tag_we  = (state == REFILL) && mem_ack && last_word;

    cache_array u_array (
        .clk         (clk),
        .reset       (reset),
        .rd_index    (addr_index),
        .rd_line     (rd_line),
        .word_we     (word_we),
        .word_index  (addr_index),
        .word_offset ((state == REFILL) ? count : addr_offset),
        .word_data   ((state == REFILL) ? mem_rdata : store_data),
        .tag_we      (tag_we),
        .tag_index   (addr_index),
        .tag_value   (addr_tag)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            store_done <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (out_en)
                        store_done <= 1'b0;
                    if (enable_cache && is_load && !hit) begin
                        state    <= REFILL;
                        count    <= '0;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= {addr_tag, addr_index, OFFSET_W'(0)};
                    end else if (enable_cache && is_store && !store_done) begin
                        state     <= WRITE;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= tlblookup_result;
                        mem_wdata <= store_data;
                    end
                end
                REFILL: begin
                    if (mem_ack) begin
                        if (last_word) begin
                            state   <= IDLE;
                            mem_req <= 1'b0;
                        end else begin
                            count    <= count + 1'b1;
                            mem_addr <= {addr_tag, addr_index, count + 1'b1};
                        end
                    end
                end
                WRITE: begin
                    // The completion cycle back in IDLE loads the output without re-issuing.
                    if (mem_ack) begin
                        state      <= IDLE;
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        store_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    pipe_reg #(.WIDTH(22)) u_out_reg (
        .clk   (clk),
        .reset (reset),
        .en    (out_en),
        .d     ({(is_load ? rd_line.data[addr_offset] : tlblookup_result),
                 destReg_addr_input, we_input, bp_input}),
        .q     (out_q)
    );

    assign {cache_result, destReg_addr_output, we_output, bp_output} = out_q;

`ifdef CACHE_STATS_EN
    logic refilled;

    // A load that refilled re-evaluates as a hit; it was already counted as a miss.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
            refilled   <= 1'b0;
        end else begin
            if (tag_we)
                refilled <= 1'b1;
            else if (out_en && is_load)
                refilled <= 1'b0;
            if (out_en && is_load && !refilled && hit_count != 16'hFFFF)
                hit_count <= hit_count + 1'b1;
            if (state == IDLE && enable_cache && is_load && !hit && miss_count != 16'hFFFF)
                miss_count <= miss_count + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_cache_stage.sv
// tb/tb_cache_stage.sv - scoreboard bench for cache_stage with a 2-cycle-ack memory model
module tb_cache_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable_cache = 1'b0;
    logic [15:0] tlblookup_result = '0;
    logic [2:0]  destReg_addr_input = '0;
    logic        we_input = 1'b0;
    logic [1:0]  bp_input = '0;
    logic        is_load = 1'b0;
    logic        is_store = 1'b0;
    logic [15:0] store_data = '0;
    logic [15:0] cache_result;
    logic [2:0]  destReg_addr_output;
    logic        we_output;
    logic [1:0]  bp_output;
    logic        stall_pipeline;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack = 1'b0;
`ifdef CACHE_STATS_EN
    logic [15:0] hit_count, miss_count;
`endif

    int n_cmp = 0;
    int n_fail = 0;
    int mem_txns = 0;
    logic [21:0] out_q [$];
    logic [32:0] mem_q [$];

    always #5 clk = ~clk;

    cache_stage dut (
        .clk(clk), .reset(reset), .enable_cache(enable_cache),
        .tlblookup_result(tlblookup_result), .destReg_addr_input(destReg_addr_input),
        .we_input(we_input), .bp_input(bp_input), .is_load(is_load), .is_store(is_store),
        .store_data(store_data), .cache_result(cache_result),
        .destReg_addr_output(destReg_addr_output), .we_output(we_output), .bp_output(bp_output),
        .stall_pipeline(stall_pipeline), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef CACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    // Memory: each request is acknowledged on its second cycle; reads return 0xA000 + (addr - 0x10).
    assign mem_rdata = 16'hA000 + (mem_addr - 16'h0010);
    always @(posedge clk) begin
        if (reset) mem_ack <= 1'b0;
        else       mem_ack <= mem_req && !mem_ack;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: pops the output and memory scoreboards whenever the DUT presents a transfer.
    initial begin : monitor
        logic        fire, mfire;
        logic [32:0] mobs, mexp;
        forever begin
            @(negedge clk);
            #2;
            fire  = enable_cache && !stall_pipeline && !reset;
            mfire = mem_req && mem_ack && !reset;
            mobs  = {mem_we, mem_addr, mem_wdata};
            if (mfire) begin
                mem_txns++;
                if (mem_q.size() == 0) begin
                    check("unexpected_mem", mobs, 33'h0);
                end else begin
                    mexp = mem_q.pop_front();
                    if (mexp[32]) check("mem_write", mobs, mexp);
                    else          check("mem_read", {mobs[32:16], 16'h0}, {mexp[32:16], 16'h0});
                end
            end
            @(posedge clk);
            #1;
            if (fire) begin
                if (out_q.size() == 0)
                    check("unexpected_out", {cache_result, destReg_addr_output, we_output, bp_output}, 0);
                else
                    check("out_regs", {cache_result, destReg_addr_output, we_output, bp_output},
                          {10'h0, out_q.pop_front()});
            end
        end
    end

    task automatic run_op(input logic ld, input logic st, input logic [15:0] addr,
                          input logic [15:0] sd, input logic [2:0] dr, input logic w,
                          input logic [1:0] b, input logic [15:0] exp_res, output int stalls);
        @(negedge clk);
        enable_cache = 1'b1; is_load = ld; is_store = st; tlblookup_result = addr;
        store_data = sd; destReg_addr_input = dr; we_input = w; bp_input = b;
        out_q.push_back({exp_res, dr, w, b});
        stalls = 0;
        #2;
        while (stall_pipeline && stalls < 200) begin
            stalls++;
            @(negedge clk);
            #2;
        end
        if (stalls >= 200) check("op_timeout", stalls, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic push_reads(input logic [15:0] base);
        for (int i = 0; i < 4; i++)
            mem_q.push_back({1'b0, base + 16'(i), 16'h0});
    endtask

    initial begin : stimulus
        int st;
        int txn_before;
        int waited;
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin : main
        int st;
        int txn_before;
        int waited;
        repeat (2) @(negedge clk);
        #2;
        check("rst_cache_result", cache_result, 16'h0);
        check("rst_dest", destReg_addr_output, 3'd0);
        check("rst_we_bp", {we_output, bp_output}, 3'd0);
        check("rst_mem_req_we", {mem_req, mem_we}, 2'b00);
        check("rst_mem_addr_wdata", {mem_addr, mem_wdata}, 32'h0);
        check("rst_stall", stall_pipeline, 1'b0);
        reset = 1'b0;

        run_op(1'b0, 1'b0, 16'h1234, 16'h0, 3'd5, 1'b1, 2'd2, 16'h1234, st);
        check("pass_stall", st, 0);

        push_reads(16'h0010);
        run_op(1'b1, 1'b0, 16'h0010, 16'h0, 3'd1, 1'b1, 2'd0, 16'hA000, st);
        check("miss_stall_0010", st, 9);

        txn_before = mem_txns;
        run_op(1'b1, 1'b0, 16'h0012, 16'h0, 3'd2, 1'b1, 2'd1, 16'hA002, st);
        check("hit_stall_0012", st, 0);
        check("hit_no_mem", mem_txns, txn_before);

        mem_q.push_back({1'b1, 16'h0011, 16'hBEEF});
        run_op(1'b0, 1'b1, 16'h0011, 16'hBEEF, 3'd0, 1'b0, 2'd0, 16'h0011, st);
        check("store_hit_stall", st, 3);

        txn_before = mem_txns;
        run_op(1'b1, 1'b0, 16'h0011, 16'h0, 3'd3, 1'b1, 2'd3, 16'hBEEF, st);
        check("load_after_store_stall", st, 0);
        check("load_after_store_no_mem", mem_txns, txn_before);

        mem_q.push_back({1'b1, 16'h0050, 16'h1111});
        run_op(1'b0, 1'b1, 16'h0050, 16'h1111, 3'd0, 1'b0, 2'd0, 16'h0050, st);
        check("store_miss_stall", st, 3);

        push_reads(16'h0050);
        run_op(1'b1, 1'b0, 16'h0050, 16'h0, 3'd4, 1'b1, 2'd0, 16'hA040, st);
        check("no_allocate_stall", st, 9);

        push_reads(16'h0010);
        run_op(1'b1, 1'b0, 16'h0010, 16'h0, 3'd6, 1'b0, 2'd1, 16'hA000, st);
        check("evicted_reload_stall", st, 9);

        // Reset during the second refill word of a miss to line 1.
        @(negedge clk);
        enable_cache = 1'b1; is_load = 1'b1; is_store = 1'b0; tlblookup_result = 16'h0034;
        mem_q.push_back({1'b0, 16'h0034, 16'h0});
        waited = 0;
        do begin
            @(negedge clk);
            #2;
            waited++;
        end while (!(mem_req && mem_ack) && waited < 20);
        check("rst_first_ack_seen", mem_req && mem_ack, 1'b1);
        @(negedge clk);
        check("rst_second_word_addr", mem_addr, 16'h0035);
        reset = 1'b1; enable_cache = 1'b0; is_load = 1'b0;
        @(negedge clk);
        #2;
        check("midrst_mem_req", mem_req, 1'b0);
        check("midrst_stall", stall_pipeline, 1'b0);
        check("midrst_cache_result", cache_result, 16'h0);
        reset = 1'b0;

        push_reads(16'h0010);
        run_op(1'b1, 1'b0, 16'h0010, 16'h0, 3'd7, 1'b1, 2'd2, 16'hA000, st);
        check("post_rst_refill_stall", st, 9);

        // With the stage disabled the output register holds.
        @(negedge clk);
        enable_cache = 1'b0; is_load = 1'b0; tlblookup_result = 16'h5555;
        repeat (2) @(negedge clk);
        #2;
        check("disabled_hold", {cache_result, destReg_addr_output}, {16'hA000, 3'd7});
        check("disabled_no_stall", stall_pipeline, 1'b0);

        repeat (3) @(negedge clk);
        check("out_q_drained", out_q.size(), 0);
        check("mem_q_drained", mem_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
